// File: rtl/blink_dec_iter_ctrl_if.sv
// Handshake bundle for the Blink-128 iterative decryption controller:
// ciphertext in, plaintext out, and the round-tweakey lookup toward the store.
interface blink_dec_iter_ctrl_if #(
  parameter int BLOCK_LEN = 128,
  parameter int IDX_W     = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BLOCK_LEN-1:0] in_ct;
  logic [IDX_W-1:0]     tk_idx;
  logic [BLOCK_LEN-1:0] tk_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [BLOCK_LEN-1:0] out_pt;

  modport master (
    output in_valid, in_ct, tk_in, out_ready,
    input  in_ready, tk_idx, out_valid, out_pt
  );

  modport slave (
    input  in_valid, in_ct, tk_in, out_ready,
    output in_ready, tk_idx, out_valid, out_pt
  );
endinterface

// File: rtl/blink_dec_iter_ctrl.sv
// Blink-128 iterative decryption controller: owns the state register and applies
// one inverse round per clock, walking the tweakey index from NUM_ROUNDS-1 down to 0.
module blink_dec_iter_ctrl #(
  parameter int BLOCK_LEN  = 128,
  parameter int NUM_ROUNDS = 16,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  blink_dec_iter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ctr_q, ctr_d;
  logic [BLOCK_LEN-1:0] data_q, data_d;

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // InvShuffleCells (cell i <- cell 5i+3 mod 16), then per-column "xor of the other
  // three cells" mix with the round tweakey folded in, then nibble-wise inverse S-box.
  function automatic logic [127:0] r_inv(input logic [127:0] s, input logic [127:0] k);
    logic [7:0]   sh [16];
    logic [7:0]   col;
    logic [7:0]   mx;
    logic [127:0] r;
    r   = 128'd0;
    col = 8'd0;
    mx  = 8'd0;
    for (int i = 0; i < 16; i++) begin
      sh[i] = s[8*((5*i+3)%16) +: 8];
    end
    for (int c = 0; c < 4; c++) begin
      col = sh[4*c] ^ sh[4*c+1] ^ sh[4*c+2] ^ sh[4*c+3];
      for (int j = 0; j < 4; j++) begin
        mx = col ^ sh[4*c+j] ^ k[8*(4*c+j) +: 8];
        r[8*(4*c+j) +: 8] = {inv_sbox4(mx[7:4]), inv_sbox4(mx[3:0])};
      end
    end
    return r;
  endfunction

  // State register, round counter and block register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      data_q  <= data_d;
    end
  end

  // Next-state: flush overrides every transition and clears the datapath.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    data_d  = data_q;
    if (flush) begin
      state_d = S_IDLE;
      ctr_d   = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            data_d  = bus.in_ct;
            ctr_d   = IDX_W'(NUM_ROUNDS - 1);
            state_d = S_ROUND;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ROUND: begin
          data_d = r_inv(data_q, bus.tk_in);
          if (ctr_q == '0) begin
            state_d = S_DONE;
          end else begin
            ctr_d = ctr_q - IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          ctr_d   = '0;
          data_d  = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches a handshake output.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.tk_idx    = '0;
    bus.out_pt    = '0;
    busy          = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
      end
      S_ROUND: begin
        busy       = 1'b1;
        bus.tk_idx = ctr_q;
      end
      S_DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_pt    = data_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_blink_dec_iter_ctrl.sv
// Self-checking bench for blink_dec_iter_ctrl: scoreboard of golden plaintexts
// from an independent Blink-128 inverse model, one task per scenario.
module tb_blink_dec_iter_ctrl;

  localparam int NR = 16;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  logic flush1;
  logic busy1;

  int n_checks;
  int n_fail;

  logic [127:0] tk_mem [16];
  logic [3:0]   inv_sb [16];
  logic [127:0] exp_q [$];
  logic [127:0] exp1_q [$];

  blink_dec_iter_ctrl_if #(.BLOCK_LEN(128), .IDX_W(8)) bus ();
  blink_dec_iter_ctrl_if #(.BLOCK_LEN(128), .IDX_W(8)) bus1 ();

  assign bus.tk_in  = tk_mem[bus.tk_idx[3:0]];
  assign bus1.tk_in = tk_mem[bus1.tk_idx[3:0]];

  blink_dec_iter_ctrl #(.BLOCK_LEN(128), .NUM_ROUNDS(NR), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .bus(bus)
  );

  blink_dec_iter_ctrl #(.BLOCK_LEN(128), .NUM_ROUNDS(1), .IDX_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .busy(busy1), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Golden round: routes each source byte to its destination (inverse of the shuffle).
  function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k);
    logic [7:0]   b [16];
    logic [7:0]   sh [16];
    logic [7:0]   mx;
    logic [127:0] r;
    r = 128'd0;
    for (int j = 0; j < 16; j++) b[j] = s[8*j +: 8];
    for (int j = 0; j < 16; j++) sh[(13 * (j + 13)) % 16] = b[j];
    for (int i = 0; i < 16; i++) begin
      mx = sh[i ^ 1] ^ sh[i ^ 2] ^ sh[i ^ 3] ^ k[8*i +: 8];
      r[8*i +: 8] = {inv_sb[mx[7:4]], inv_sb[mx[3:0]]};
    end
    return r;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] ct, input int nr);
    logic [127:0] s;
    s = ct;
    for (int r = nr - 1; r >= 0; r--) s = m_round(s, tk_mem[r]);
    return s;
  endfunction

  task automatic send(input logic [127:0] ct);
    bus.in_valid = 1'b1;
    bus.in_ct    = ct;
    exp_q.push_back(dec_model(ct, NR));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_ct    = rnd128();
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idx(input logic [7:0] idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tk_idx == idx && busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_ct     = rnd128();
      bus.out_ready = 1'($urandom);
      flush         = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.tk_idx !== 8'd0 || bus.out_pt !== 128'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ov=%b busy=%b idx=%0d pt=%h want 0,0,0,0",
                 bus.out_valid, busy, bus.tk_idx, bus.out_pt);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b busy=%b want 1,0", bus.in_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [127:0] want;
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_in_ready: got %b want 1", bus.in_ready);
    end
    send(128'h0123456789abcdef0123456789abcdef);
    for (int k = 1; k <= NR; k++) begin
      n_checks++;
      if (bus.tk_idx !== 8'(NR - k) || busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_round c%0d: got idx=%0d busy=%b ir=%b ov=%b want idx=%0d,1,0,0",
                 k, bus.tk_idx, busy, bus.in_ready, bus.out_valid, NR - k);
      end
      @(negedge clk);
    end
    want = exp_q.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pt !== want) begin
      n_fail++;
      $display("FAIL single_result: got ov=%b pt=%h want 1 pt=%h", bus.out_valid, bus.out_pt, want);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_return: got ov=%b ir=%b want 0,1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b0;
    send(rnd128());
    wait_out(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: got no out_valid want out_valid within 60 cycles");
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pt !== exp_q[0] || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: got ov=%b ir=%b pt=%h want 1,0 pt=%h",
                 c, bus.out_valid, bus.in_ready, bus.out_pt, exp_q[0]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.out_pt !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL bp_result: got pt=%h", bus.out_pt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got ir=%b ov=%b want 1,0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [3];
    logic [127:0] want;
    int acc, got, last_out, cyc;
    bit prev_acc;
    acc = 0; got = 0; last_out = -1; cyc = 0; prev_acc = 1'b0;
    for (int i = 0; i < 3; i++) blk[i] = rnd128() ^ 128'(i);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ct     = blk[0];
    while (got < 3 && cyc < 120) begin
      if (prev_acc) begin
        n_checks++;
        if (bus.tk_idx !== 8'(NR - 1)) begin
          n_fail++;
          $display("FAIL b2b_idx_restart blk%0d: got %0d want %0d", acc - 1, bus.tk_idx, NR - 1);
        end
      end
      prev_acc = 1'b0;
      if (bus.out_valid) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_checks++;
        if (bus.out_pt !== want) begin
          n_fail++;
          $display("FAIL b2b_result blk%0d: got %h want %h", got, bus.out_pt, want);
        end
        if (last_out >= 0) begin
          n_checks++;
          if (cyc - last_out != NR + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_out, NR + 2);
          end
        end
        last_out = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(dec_model(bus.in_ct, NR));
        prev_acc = 1'b1;
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (prev_acc) begin
        if (acc < 3) bus.in_ct = blk[acc];
        else bus.in_valid = 1'b0;
      end
    end
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 3", got);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    send(rnd128());
    wait_idx(8'd7, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ar_reach_idx7: got no tk_idx=7 want tk_idx=7");
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.tk_idx !== 8'd0 || bus.out_valid !== 1'b0 || bus.out_pt !== 128'd0) begin
      n_fail++;
      $display("FAIL ar_immediate: got busy=%b idx=%0d ov=%b pt=%h want 0,0,0,0",
               busy, bus.tk_idx, bus.out_valid, bus.out_pt);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(rnd128());
    wait_out(ok);
    n_checks++;
    if (!ok || bus.out_pt !== exp_q[0]) begin
      n_fail++;
      $display("FAIL ar_next_block: got ok=%b pt=%h want %h", ok, bus.out_pt, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit ok;
    send(rnd128());
    wait_idx(8'd10, ok);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (!ok || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.tk_idx !== 8'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_round: got ok=%b busy=%b ir=%b idx=%0d ov=%b want 1,0,1,0,0",
               ok, busy, bus.in_ready, bus.tk_idx, bus.out_valid);
    end
    exp_q.delete();
    bus.out_ready = 1'b0;
    send(rnd128());
    wait_out(ok);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (!ok || bus.out_valid !== 1'b0 || bus.out_pt !== 128'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: got ok=%b ov=%b ir=%b pt=%h want 1,0,1,0",
               ok, bus.out_valid, bus.in_ready, bus.out_pt);
    end
    exp_q.delete();
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ct     = rnd128();
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_idle_noaccept c%0d: got busy=%b ir=%b want 0,1", c, busy, bus.in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_one_round();
    logic [127:0] ct;
    ct = rnd128();
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_ct     = ct;
    exp1_q.push_back(dec_model(ct, 1));
    @(negedge clk);
    bus1.in_valid = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1 || bus1.tk_idx !== 8'd0 || bus1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nr1_round: got busy=%b idx=%0d ov=%b want 1,0,0", busy1, bus1.tk_idx, bus1.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_pt !== exp1_q[0]) begin
      n_fail++;
      $display("FAIL nr1_result: got ov=%b pt=%h want 1 pt=%h", bus1.out_valid, bus1.out_pt, exp1_q[0]);
    end
    void'(exp1_q.pop_front());
    bus1.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nr1_return: got ov=%b ir=%b want 0,1", bus1.out_valid, bus1.in_ready);
    end
  endtask

  initial begin
    logic [63:0] fwd;
    n_checks = 0;
    n_fail   = 0;
    fwd = 64'hC56B90AD3EF84712;
    for (int x = 0; x < 16; x++) inv_sb[fwd[63-4*x -: 4]] = 4'(x);
    for (int r = 0; r < 16; r++) tk_mem[r] = rnd128();
    rst_n          = 1'b0;
    flush          = 1'b0;
    flush1         = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_ct      = 128'd0;
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_ct     = 128'd0;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_flush();
    test_one_round();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
